// File: rtl/puf_soc_ro_meas.sv
// RO-PUF measurement back end: counts edges of two ring oscillators over a gate window and compares them.
// Latency: result valid SETTLE_CYC + win_len + 1 cycles after an accepted start (1 cycle for a zero window).
// Backpressure: result and all outputs hold in DONE until i_ready; starts outside IDLE are ignored.
`timescale 1ns/100ps
module puf_soc_ro_meas #(
    parameter int CNT_BIT_SIZE = 16,
    parameter int WIN_BIT_SIZE = 12,
    parameter int SETTLE_CYC   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [WIN_BIT_SIZE-1:0] i_win_len,
    input  logic                    i_ro_a,
    input  logic                    i_ro_b,
    output logic                    o_ro_en,
    output logic                    o_busy,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_resp,
    output logic [CNT_BIT_SIZE-1:0] o_cnt_a,
    output logic [CNT_BIT_SIZE-1:0] o_cnt_b,
    output logic                    o_ovf
);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_BIT_SIZE-1:0] CNT_MAX = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic                    a_meta, a_sync, a_prev;
    logic                    b_meta, b_sync, b_prev;
    logic                    edge_a, edge_b;
    logic [SET_W-1:0]        settle_cnt;
    logic [WIN_BIT_SIZE-1:0] win_reg;
    logic [WIN_BIT_SIZE-1:0] win_cnt;
    logic [CNT_BIT_SIZE-1:0] cnt_a, cnt_b;
    logic                    ovf;
    logic                    start_ok;
    logic                    settle_last;
    logic                    win_last;

    assign start_ok    = (state == IDLE) && i_start;
    assign settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));
    // win_reg is never zero while in COUNT, so the subtraction cannot wrap there
    assign win_last    = (win_cnt == win_reg - 1'b1);
    assign edge_a      = a_sync & ~a_prev;
    assign edge_b      = b_sync & ~b_prev;

    // Two-flop synchronisers followed by a previous-value register for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            a_prev <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
            b_prev <= 1'b0;
        end else begin
            a_meta <= i_ro_a;
            a_sync <= a_meta;
            a_prev <= a_sync;
            b_meta <= i_ro_b;
            b_sync <= b_meta;
            b_prev <= b_sync;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a zero window skips straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = (i_win_len == '0) ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (win_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; comparison is unsigned and a tie reports 0
    always_comb begin
        o_ro_en = (state == SETTLE) || (state == COUNT);
        o_busy  = (state != IDLE);
        o_valid = (state == DONE);
        o_resp  = (cnt_a > cnt_b);
        o_cnt_a = cnt_a;
        o_cnt_b = cnt_b;
        o_ovf   = ovf;
    end

    // Settle and window timers run only in their own state and sit at zero otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            win_reg    <= '0;
        end else begin
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            win_cnt    <= (state == COUNT) ? win_cnt + 1'b1 : '0;
            if (start_ok) begin
                win_reg <= i_win_len;
            end
        end
    end

    // Saturating edge counters with a sticky overflow flag, cleared on an accepted start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
            ovf   <= 1'b0;
        end else if (start_ok) begin
            cnt_a <= '0;
            cnt_b <= '0;
            ovf   <= 1'b0;
        end else if (state == COUNT) begin
            if (edge_a) begin
                if (cnt_a == CNT_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    cnt_a <= cnt_a + 1'b1;
                end
            end
            if (edge_b) begin
                if (cnt_b == CNT_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    cnt_b <= cnt_b + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_soc_ro_meas.sv
// Bench for puf_soc_ro_meas: two instances (16-bit and 4-bit counters) share all stimulus.
// Timeline-level reference model computes counts from sampled RO levels; checked every cycle.
// Literal checks pin the model for the basic, swapped, tie, saturation, zero-window and reset cases.
`timescale 1ns/100ps
module tb_puf_soc_ro_meas;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [11:0] win_len = '0;
    logic        ro_a = 1'b0;
    logic        ro_b_gen = 1'b0;
    logic        lock_b = 1'b0;
    logic        ro_b;
    int          half_a = 40;
    int          half_b = 50;

    logic        en16, busy16, valid16, resp16, ovf16;
    logic [15:0] ca16, cb16;
    logic        en4, busy4, valid4, resp4, ovf4;
    logic [3:0]  ca4, cb4;

    int checks = 0;
    int failures = 0;

    assign ro_b = lock_b ? ro_a : ro_b_gen;

    puf_soc_ro_meas #(.CNT_BIT_SIZE(16), .WIN_BIT_SIZE(12), .SETTLE_CYC(S)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_win_len(win_len),
        .i_ro_a(ro_a), .i_ro_b(ro_b), .o_ro_en(en16), .o_busy(busy16),
        .o_valid(valid16), .i_ready(ready), .o_resp(resp16),
        .o_cnt_a(ca16), .o_cnt_b(cb16), .o_ovf(ovf16)
    );

    puf_soc_ro_meas #(.CNT_BIT_SIZE(4), .WIN_BIT_SIZE(12), .SETTLE_CYC(S)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_win_len(win_len),
        .i_ro_a(ro_a), .i_ro_b(ro_b), .o_ro_en(en4), .o_busy(busy4),
        .o_valid(valid4), .i_ready(ready), .o_resp(resp4),
        .o_cnt_a(ca4), .o_cnt_b(cb4), .o_ovf(ovf4)
    );

    initial forever #5 clk = ~clk;

    // Free-running oscillators; the 0.3 ns offset keeps transitions off clock edges
    initial begin
        #0.3;
        forever begin
            #(half_a);
            ro_a = ~ro_a;
        end
    end

    initial begin
        #0.3;
        forever begin
            #(half_b);
            ro_b_gen = ~ro_b_gen;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic int sat(input int raw, input int w);
        int m;
        m = (1 << w) - 1;
        return (raw > m) ? m : raw;
    endfunction

    // ---------------- reference model ----------------
    // A measurement is a timeline: start accepted at edge m_start, result visible
    // after edge m_done. A rising RO transition between the samples taken at
    // edges e-3 and e-2 is counted at edge e if e lies inside the window.
    int  cyc = 0;
    bit  hist_a [0:65535];
    bit  hist_b [0:65535];
    bit  m_busy = 1'b0;
    int  m_start = 0;
    int  m_win = 0;
    int  m_done = 0;
    int  raw_a = 0;
    int  raw_b = 0;

    always @(posedge clk) begin
        cyc++;
        if (cyc < 65536) begin
            hist_a[cyc] = ro_a;
            hist_b[cyc] = ro_b;
        end
        if (rst) begin
            m_busy = 1'b0;
            raw_a  = 0;
            raw_b  = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  = 1'b1;
                m_start = cyc;
                m_win   = int'(win_len);
                m_done  = (m_win == 0) ? cyc : cyc + S + m_win;
                raw_a   = 0;
                raw_b   = 0;
            end
        end else if (cyc > m_done && ready) begin
            m_busy = 1'b0;
        end else if (cyc >= m_start + S + 1 && cyc <= m_start + S + m_win && cyc < 65536) begin
            raw_a += int'(hist_a[cyc-2] & ~hist_a[cyc-3]);
            raw_b += int'(hist_b[cyc-2] & ~hist_b[cyc-3]);
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            chk("rst_ctl16", int'({en16, busy16, valid16, resp16, ovf16}), 0);
            chk("rst_cnt16", int'({ca16, cb16}), 0);
            chk("rst_ctl4", int'({en4, busy4, valid4, resp4, ovf4}), 0);
            chk("rst_cnt4", int'({ca4, cb4}), 0);
        end else begin
            ev = m_busy && (cyc >= m_done);
            chk("busy16", int'(busy16), int'(m_busy));
            chk("valid16", int'(valid16), int'(ev));
            chk("ro_en16", int'(en16), int'(m_busy && !ev));
            chk("busy4", int'(busy4), int'(m_busy));
            chk("valid4", int'(valid4), int'(ev));
            if (m_busy) begin
                chk("cnt_a16", int'(ca16), sat(raw_a, 16));
                chk("cnt_b16", int'(cb16), sat(raw_b, 16));
                chk("ovf16", int'(ovf16), int'(raw_a > 65535 || raw_b > 65535));
                chk("cnt_a4", int'(ca4), sat(raw_a, 4));
                chk("cnt_b4", int'(cb4), sat(raw_b, 4));
                chk("ovf4", int'(ovf4), int'(raw_a > 15 || raw_b > 15));
                if (ev) begin
                    chk("resp16", int'(resp16), int'(sat(raw_a, 16) > sat(raw_b, 16)));
                    chk("resp4", int'(resp4), int'(sat(raw_a, 4) > sat(raw_b, 4)));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int res_lat, res_a, res_b, res_a4;
    bit res_resp, res_ovf, res_ovf4, res_en;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_meas(input int ha, input int hb, input bit lock, input int w,
                           input int stray, input int stall);
        int k;
        int n;
        half_a  = ha;
        half_b  = hb;
        lock_b  = lock;
        k       = cyc;
        start   = 1'b1;
        win_len = 12'(w);
        tick();
        start = 1'b0;
        n = 0;
        while (!valid16 && n < S + w + 20) begin
            start   = (n == stray);
            win_len = 12'($urandom);
            tick();
            n++;
        end
        start = 1'b0;
        if (!valid16) begin
            chk("valid_timeout", 0, 1);
        end
        res_lat  = cyc - k;
        res_a    = int'(ca16);
        res_b    = int'(cb16);
        res_resp = resp16;
        res_ovf  = ovf16;
        res_a4   = int'(ca4);
        res_ovf4 = ovf4;
        res_en   = en16;
        repeat (stall) begin
            start = ($urandom_range(0, 2) == 0);
            tick();
        end
        start = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("idle_after_ready", int'(busy16), 0);
    endtask

    initial begin
        #1;
        chk("reset_outputs", int'({en16, busy16, valid16, resp16, ovf16, ca16, cb16}), 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(busy16), 0);

        // Basic compare: A period 80 ns, B period 100 ns, 800-cycle window
        do_meas(40, 50, 1'b0, 800, -1, 2);
        chk("basic_latency", res_lat, S + 801);
        chk_rng("basic_cnt_a", res_a, 99, 101);
        chk_rng("basic_cnt_b", res_b, 79, 81);
        chk("basic_resp", int'(res_resp), 1);
        chk("basic_ovf", int'(res_ovf), 0);

        // Swapped periods
        do_meas(50, 40, 1'b0, 800, -1, 0);
        chk_rng("swap_cnt_a", res_a, 79, 81);
        chk("swap_resp", int'(res_resp), 0);

        // Identical phase-aligned oscillators
        do_meas(35, 35, 1'b1, 500, -1, 1);
        chk("tie_equal", res_a, res_b);
        chk_rng("tie_cnt_a", res_a, 70, 72);
        chk("tie_resp", int'(res_resp), 0);

        // Saturation of the 4-bit instance: 40 ns period over 200 cycles
        do_meas(20, 30, 1'b0, 200, -1, 0);
        chk("sat_cnt_a4", res_a4, 15);
        chk("sat_ovf4", int'(res_ovf4), 1);
        chk("sat_ovf16", int'(res_ovf), 0);
        chk_rng("sat_cnt_a16", res_a, 49, 51);

        // Zero window right after: overflow clears, no enable, result next cycle
        do_meas(20, 30, 1'b0, 0, -1, 0);
        chk("zero_latency", res_lat, 1);
        chk("zero_cnt_a", res_a, 0);
        chk("zero_cnt_b", res_b, 0);
        chk("zero_resp", int'(res_resp), 0);
        chk("zero_ovf4_cleared", int'(res_ovf4), 0);
        chk("zero_ro_en", int'(res_en), 0);

        // Handshake stall with stray starts during COUNT and DONE
        do_meas(40, 45, 1'b0, 100, 30, 20);
        chk("stall_resp", int'(res_resp), 1);

        // Asynchronous reset in the middle of COUNT
        half_a  = 40;
        half_b  = 50;
        lock_b  = 1'b0;
        start   = 1'b1;
        win_len = 12'd300;
        tick();
        start = 1'b0;
        repeat (S + 50) tick();
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ctl", int'({en16, busy16, valid16, resp16, ovf16}), 0);
        chk("midrst_cnt", int'({ca16, cb16}), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", int'(busy16), 0);

        // Randomised measurements
        for (int i = 0; i < 12; i++) begin
            do_meas($urandom_range(12, 60), $urandom_range(12, 60),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 300),
                    $urandom_range(0, 40), $urandom_range(0, 5));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
